// File: rtl/filter_int.sv
// Integer interpolator: buffers input samples in a 2-entry FIFO and expands each
// sample into F = mode+1 output slots (zero-stuffed or sample-held), paced by out_stb.
module filter_int #(
  parameter int DATA_WD    = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               cfg_rst,
  input  logic [5:0]         mode,
  input  logic               fill_mode,
  input  logic               din_valid,
  output logic               din_ready,
  input  logic [DATA_WD-1:0] din,
  input  logic               out_stb,
  output logic               dout_valid,
  output logic [DATA_WD-1:0] dout,
  output logic               dout_first,
  output logic               underrun
);

  localparam int PTR_WD = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_WD = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } state_t;

  logic [DATA_WD-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_WD-1:0]  r_wptr;
  logic [PTR_WD-1:0]  r_rptr;
  logic [CNT_WD-1:0]  r_count;

  state_t             r_state;
  logic [5:0]         r_cnt;
  logic [5:0]         r_fl;
  logic               r_fill;
  logic [DATA_WD-1:0] r_hold;
  logic               r_armed;
  logic               r_underrun;
  logic               r_dout_valid;
  logic [DATA_WD-1:0] r_dout;
  logic               r_dout_first;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [DATA_WD-1:0] w_head;
  state_t             w_state_nxt;
  logic [5:0]         w_cnt_nxt;
  logic               w_emit;
  logic               w_emit_first;
  logic [DATA_WD-1:0] w_emit_data;
  logic               w_set_underrun;

  // Occupancy is registered, so ready never depends on this cycle's out_stb.
  assign w_full    = (r_count == CNT_WD'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign din_ready = ~w_full;
  assign w_push    = din_valid & ~w_full & ~cfg_rst & ~sys_rst;
  assign w_head    = r_mem[r_rptr];

  function automatic logic [PTR_WD-1:0] ptrInc(input logic [PTR_WD-1:0] ptr);
    return (ptr == PTR_WD'(FIFO_DEPTH - 1)) ? '0 : ptr + PTR_WD'(1);
  endfunction

  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst || cfg_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= ptrInc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptrInc(r_rptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_WD'(1);
        2'b01:   r_count <= r_count - CNT_WD'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_pop          = 1'b0;
    w_emit         = 1'b0;
    w_emit_first   = 1'b0;
    w_emit_data    = '0;
    w_set_underrun = 1'b0;
    if (out_stb) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_emit       = 1'b1;
            w_emit_first = 1'b1;
            w_emit_data  = w_head;
            if (mode != 6'd0) begin
              w_state_nxt = ST_EMIT;
              w_cnt_nxt   = 6'd1;
            end
          end else if (r_armed) begin
            w_set_underrun = 1'b1;
          end
        end
        ST_EMIT: begin
          w_emit      = 1'b1;
          w_emit_data = r_fill ? r_hold : '0;
          if (r_cnt == r_fl) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 6'd0;
          end else begin
            w_cnt_nxt = r_cnt + 6'd1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 6'd0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst || cfg_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 6'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Burst parameters are captured at pop so mid-burst mode changes wait for the next sample.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_hold <= '0;
      r_fl   <= 6'd0;
      r_fill <= 1'b0;
    end else if (!cfg_rst && w_pop) begin
      r_hold <= w_head;
      r_fl   <= mode;
      r_fill <= fill_mode;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_armed      <= 1'b0;
      r_underrun   <= 1'b0;
      r_dout_valid <= 1'b0;
      r_dout_first <= 1'b0;
      r_dout       <= '0;
    end else if (cfg_rst) begin
      r_armed      <= 1'b0;
      r_underrun   <= 1'b0;
      r_dout_valid <= 1'b0;
      r_dout_first <= 1'b0;
    end else begin
      r_dout_valid <= w_emit;
      r_dout_first <= w_emit & w_emit_first;
      if (w_emit) begin
        r_dout <= w_emit_data;
      end
      if (w_pop) begin
        r_armed <= 1'b1;
      end
      if (w_set_underrun) begin
        r_underrun <= 1'b1;
      end
    end
  end

  assign dout_valid = r_dout_valid;
  assign dout       = r_dout;
  assign dout_first = r_dout_first;
  assign underrun   = r_underrun;

endmodule

// File: tb/tb_filter_int.sv
// Self-checking bench for filter_int: directed scenarios against fixed expectations
// plus randomized traffic against a queue-based model of the interpolator.
module tb_filter_int;

  logic        sys_clk;
  logic        sys_rst;
  logic        cfg_rst;
  logic [5:0]  mode;
  logic        fill_mode;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] din;
  logic        out_stb;
  logic        dout_valid;
  logic [31:0] dout;
  logic        dout_first;
  logic        underrun;

  int passCount;
  int totalCount;

  filter_int #(.DATA_WD(32), .FIFO_DEPTH(2)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .cfg_rst   (cfg_rst),
    .mode      (mode),
    .fill_mode (fill_mode),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .din       (din),
    .out_stb   (out_stb),
    .dout_valid(dout_valid),
    .dout      (dout),
    .dout_first(dout_first),
    .underrun  (underrun)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Model: accepted samples wait in sampleQ; a popped sample expands into its whole
  // list of pending output slots, and each out_stb consumes one of those slots.
  typedef struct {
    logic [31:0] data;
    logic        first;
  } slot_t;

  logic [31:0] sampleQ[$];
  slot_t       slotQ[$];
  logic        mArmed;
  logic        mUnderrun;
  logic        mValid;
  logic        mFirst;
  logic [31:0] mDout;
  logic        mReady;

  task automatic model_step();
    logic  canAccept;
    logic [31:0] s;
    slot_t sl;
    if (sys_rst) begin
      sampleQ.delete(); slotQ.delete();
      mArmed = 0; mUnderrun = 0; mValid = 0; mFirst = 0; mDout = 0;
    end else if (cfg_rst) begin
      sampleQ.delete(); slotQ.delete();
      mArmed = 0; mUnderrun = 0; mValid = 0; mFirst = 0;
    end else begin
      canAccept = (sampleQ.size() < 2);
      mValid = 0;
      mFirst = 0;
      if (out_stb) begin
        if (slotQ.size() == 0 && sampleQ.size() > 0) begin
          s = sampleQ.pop_front();
          mArmed = 1;
          for (int k = 0; k <= int'(mode); k++) begin
            sl.first = (k == 0);
            sl.data  = (k == 0 || fill_mode) ? s : 32'd0;
            slotQ.push_back(sl);
          end
        end
        if (slotQ.size() > 0) begin
          sl = slotQ.pop_front();
          mValid = 1;
          mFirst = sl.first;
          mDout  = sl.data;
        end else if (mArmed) begin
          mUnderrun = 1;
        end
      end
      if (din_valid && canAccept) sampleQ.push_back(din);
    end
    mReady = (sampleQ.size() < 2);
  endtask

  task automatic cycle(input logic v, input logic [31:0] d, input logic stb);
    din_valid = v;
    din       = d;
    out_stb   = stb;
    model_step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1; cfg_rst = 0;
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    sys_rst = 0;
  endtask

  task automatic test_reset();
    sys_rst = 1; cfg_rst = 0; mode = 6'd2; fill_mode = 1;
    cycle(1, 32'hDEAD_BEEF, 1);
    cycle(1, 32'h1234_5678, 1);
    sys_rst = 0;
    totalCount++;
    if (dout_valid !== 1'b0) $display("[TB] FAIL reset_valid got=%b want=0", dout_valid); else passCount++;
    totalCount++;
    if (dout !== 32'd0) $display("[TB] FAIL reset_dout got=%h want=0", dout); else passCount++;
    totalCount++;
    if (dout_first !== 1'b0) $display("[TB] FAIL reset_first got=%b want=0", dout_first); else passCount++;
    totalCount++;
    if (underrun !== 1'b0) $display("[TB] FAIL reset_underrun got=%b want=0", underrun); else passCount++;
    cycle(0, 0, 0);
    totalCount++;
    if (din_ready !== 1'b1) $display("[TB] FAIL reset_ready got=%b want=1", din_ready); else passCount++;
  endtask

  task automatic test_zero_stuff();
    logic [31:0] expD[4];
    expD[0] = 32'hA; expD[1] = 0; expD[2] = 0; expD[3] = 0;
    do_reset();
    mode = 6'd3; fill_mode = 0;
    cycle(1, 32'hA, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1);
      totalCount++;
      if (dout_valid !== 1'b1 || dout !== expD[i] || dout_first !== (i == 0))
        $display("[TB] FAIL zero_stuff[%0d] got v=%b d=%h f=%b want v=1 d=%h f=%b",
                 i, dout_valid, dout, dout_first, expD[i], (i == 0));
      else passCount++;
    end
    cycle(0, 0, 0);
    totalCount++;
    if (dout_valid !== 1'b0 || dout !== 32'd0)
      $display("[TB] FAIL zero_stuff_idle got v=%b d=%h want v=0 d=0", dout_valid, dout);
    else passCount++;
  endtask

  task automatic test_sample_hold();
    logic [31:0] expD[6];
    expD[0] = 32'h11; expD[1] = 32'h11; expD[2] = 32'h11;
    expD[3] = 32'h22; expD[4] = 32'h22; expD[5] = 32'h22;
    do_reset();
    mode = 6'd2; fill_mode = 1;
    cycle(1, 32'h11, 0);
    cycle(1, 32'h22, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 1);
      totalCount++;
      if (dout_valid !== 1'b1 || dout !== expD[i] || dout_first !== (i % 3 == 0))
        $display("[TB] FAIL sample_hold[%0d] got v=%b d=%h f=%b want v=1 d=%h f=%b",
                 i, dout_valid, dout, dout_first, expD[i], (i % 3 == 0));
      else passCount++;
      for (int j = 0; j < 3; j++) begin
        cycle(0, 0, 0);
        totalCount++;
        if (dout_valid !== 1'b0) $display("[TB] FAIL sample_hold_gap got=%b want=0", dout_valid);
        else passCount++;
      end
    end
    totalCount++;
    if (underrun !== 1'b0) $display("[TB] FAIL sample_hold_underrun got=%b want=0", underrun); else passCount++;
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 6'd0; fill_mode = 0;
    cycle(1, 32'd1, 0);
    totalCount++;
    if (din_ready !== 1'b1) $display("[TB] FAIL bp_ready1 got=%b want=1", din_ready); else passCount++;
    cycle(1, 32'd2, 0);
    totalCount++;
    if (din_ready !== 1'b0) $display("[TB] FAIL bp_ready2 got=%b want=0", din_ready); else passCount++;
    cycle(1, 32'd3, 0);
    totalCount++;
    if (din_ready !== 1'b0) $display("[TB] FAIL bp_ready3 got=%b want=0", din_ready); else passCount++;
    cycle(1, 32'd3, 1);
    totalCount++;
    if (din_ready !== 1'b1 || dout_valid !== 1'b1 || dout !== 32'd1)
      $display("[TB] FAIL bp_release got r=%b v=%b d=%h want r=1 v=1 d=1", din_ready, dout_valid, dout);
    else passCount++;
    cycle(1, 32'd3, 1);
    totalCount++;
    if (dout_valid !== 1'b1 || dout !== 32'd2)
      $display("[TB] FAIL bp_second got v=%b d=%h want v=1 d=2", dout_valid, dout);
    else passCount++;
    cycle(0, 0, 1);
    totalCount++;
    if (dout_valid !== 1'b1 || dout !== 32'd3)
      $display("[TB] FAIL bp_third got v=%b d=%h want v=1 d=3", dout_valid, dout);
    else passCount++;
    cycle(0, 0, 1);
    totalCount++;
    if (dout_valid !== 1'b0 || underrun !== 1'b1)
      $display("[TB] FAIL bp_drained got v=%b u=%b want v=0 u=1", dout_valid, underrun);
    else passCount++;
  endtask

  task automatic test_passthrough();
    logic [31:0] stream[20];
    do_reset();
    mode = 6'd0; fill_mode = 0;
    for (int i = 0; i < 20; i++) stream[i] = $urandom;
    for (int i = 0; i <= 20; i++) begin
      if (i < 20) cycle(1, stream[i], 1);
      else        cycle(0, 0, 1);
      if (i > 0) begin
        totalCount++;
        if (dout_valid !== 1'b1 || dout !== stream[i-1] || dout_first !== 1'b1)
          $display("[TB] FAIL passthrough[%0d] got v=%b d=%h f=%b want v=1 d=%h f=1",
                   i - 1, dout_valid, dout, dout_first, stream[i-1]);
        else passCount++;
      end
    end
  endtask

  task automatic test_underrun();
    do_reset();
    mode = 6'd1; fill_mode = 1;
    cycle(1, 32'h77, 0);
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    totalCount++;
    if (dout !== 32'h77 || underrun !== 1'b0)
      $display("[TB] FAIL ur_burst got d=%h u=%b want d=77 u=0", dout, underrun);
    else passCount++;
    cycle(0, 0, 1);
    totalCount++;
    if (underrun !== 1'b1 || dout_valid !== 1'b0)
      $display("[TB] FAIL ur_set got u=%b v=%b want u=1 v=0", underrun, dout_valid);
    else passCount++;
    cycle(0, 0, 0);
    totalCount++;
    if (underrun !== 1'b1) $display("[TB] FAIL ur_sticky got=%b want=1", underrun); else passCount++;
    cfg_rst = 1;
    cycle(1, 32'h99, 1);
    cfg_rst = 0;
    totalCount++;
    if (underrun !== 1'b0 || dout !== 32'h77 || dout_valid !== 1'b0)
      $display("[TB] FAIL ur_cfg_rst got u=%b d=%h v=%b want u=0 d=77 v=0", underrun, dout, dout_valid);
    else passCount++;
    cycle(0, 0, 1);
    totalCount++;
    if (underrun !== 1'b0 || dout_valid !== 1'b0)
      $display("[TB] FAIL ur_unarmed got u=%b v=%b want u=0 v=0", underrun, dout_valid);
    else passCount++;
  endtask

  task automatic test_mode_change();
    logic [31:0] expD[8];
    logic        expF[8];
    for (int i = 0; i < 8; i++) begin
      expD[i] = (i < 2) ? 32'h5 : 32'h6;
      expF[i] = (i == 0 || i == 2);
    end
    do_reset();
    mode = 6'd1; fill_mode = 1;
    cycle(1, 32'h5, 0);
    cycle(1, 32'h6, 0);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 1);
      if (i == 0) mode = 6'd5;
      totalCount++;
      if (dout_valid !== 1'b1 || dout !== expD[i] || dout_first !== expF[i])
        $display("[TB] FAIL mode_change[%0d] got v=%b d=%h f=%b want v=1 d=%h f=%b",
                 i, dout_valid, dout, dout_first, expD[i], expF[i]);
      else passCount++;
    end
    cycle(0, 0, 1);
    totalCount++;
    if (dout_valid !== 1'b0 || underrun !== 1'b1)
      $display("[TB] FAIL mode_change_end got v=%b u=%b want v=0 u=1", dout_valid, underrun);
    else passCount++;
  endtask

  task automatic test_random();
    do_reset();
    mode = 6'd1; fill_mode = 0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 15) == 0) mode = 6'($urandom_range(0, 4));
      if ($urandom_range(0, 15) == 0) fill_mode = 1'($urandom_range(0, 1));
      cfg_rst = ($urandom_range(0, 49) == 0);
      cycle(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 2) != 0));
      totalCount++;
      if (dout_valid !== mValid || dout_first !== mFirst || dout !== mDout ||
          underrun !== mUnderrun || din_ready !== mReady)
        $display("[TB] FAIL random[%0d] got v=%b f=%b d=%h u=%b r=%b want v=%b f=%b d=%h u=%b r=%b",
                 c, dout_valid, dout_first, dout, underrun, din_ready,
                 mValid, mFirst, mDout, mUnderrun, mReady);
      else passCount++;
    end
    cfg_rst = 0;
  endtask

  initial begin
    passCount  = 0;
    totalCount = 0;
    sys_rst = 1; cfg_rst = 0; mode = 0; fill_mode = 0;
    din_valid = 0; din = 0; out_stb = 0;
    sampleQ.delete(); slotQ.delete();
    mArmed = 0; mUnderrun = 0; mValid = 0; mFirst = 0; mDout = 0; mReady = 1;
    test_reset();
    test_zero_stuff();
    test_sample_hold();
    test_backpressure();
    test_passthrough();
    test_underrun();
    test_mode_change();
    test_random();
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
